// File: rtl/lattice_pkg.sv
// lattice_pkg
// Shared definitions for the relay lattice sequencer.
//   state_t  : sequencer FSM state encoding (IDLE / GUARD / DWELL)
//   all_off  : builds the all-ones "every relay off" drive word for a given width
package lattice_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GUARD = 2'd1,
        ST_DWELL = 2'd2
    } state_t;

    localparam int ALL_OFF_MAX_W = 256;

    // Relay pins are active-low, so "off" is every bit set. Callers cast the
    // result down to their own output width.
    function automatic logic [ALL_OFF_MAX_W-1:0] all_off(input int width);
        logic [ALL_OFF_MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < ALL_OFF_MAX_W; i++) begin
            if (i < width) v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/lattice_if.sv
// lattice_if
// Step-table configuration bus for lattice_seq.
//   cfg_we      : write strobe (accepted only while the sequencer is idle)
//   cfg_addr    : table entry to write
//   cfg_pattern : relay pin drive for that step
//   cfg_dwell   : dwell time for that step in clock cycles
//   cfg_err     : one-cycle pulse when a write was refused because the sequencer was busy
// Modports: master drives the writes, slave is the sequencer.
interface lattice_if #(
    parameter int N_RELAY = 7,
    parameter int PINS    = 3,
    parameter int DEPTH   = 32,
    parameter int DWELL_W = 24
);
    logic                       cfg_we;
    logic [$clog2(DEPTH)-1:0]   cfg_addr;
    logic [N_RELAY*PINS-1:0]    cfg_pattern;
    logic [DWELL_W-1:0]         cfg_dwell;
    logic                       cfg_err;

    modport master (
        output cfg_we, cfg_addr, cfg_pattern, cfg_dwell,
        input  cfg_err
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_pattern, cfg_dwell,
        output cfg_err
    );
endinterface

// File: rtl/lattice_tbl.sv
// lattice_tbl
// Step table: DEPTH entries of {pattern, dwell}. Synchronous write, asynchronous
// read. Contents are deliberately not reset so a sequence survives rst_n.
//   clk_in            : clock
//   we/waddr/wpattern/wdwell : write port
//   raddr/rpattern/rdwell    : combinational read port
module lattice_tbl #(
    parameter int DEPTH   = 32,
    parameter int PAT_W   = 21,
    parameter int DWELL_W = 24
) (
    input  logic                     clk_in,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [PAT_W-1:0]         wpattern,
    input  logic [DWELL_W-1:0]       wdwell,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [PAT_W-1:0]         rpattern,
    output logic [DWELL_W-1:0]       rdwell
);
    logic [PAT_W-1:0]   pat_mem   [DEPTH];
    logic [DWELL_W-1:0] dwell_mem [DEPTH];

    always_ff @(posedge clk_in) begin
        if (we) begin
            pat_mem[waddr]   <= wpattern;
            dwell_mem[waddr] <= wdwell;
        end
    end

    assign rpattern = pat_mem[raddr];
    assign rdwell   = dwell_mem[raddr];
endmodule

// File: rtl/lattice_seq.sv
// lattice_seq
// Relay pattern sequencer with break-before-make guard between steps.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | outputs all off, table writable, waiting for a valid start
//   GUARD  | outputs all off for GUARD_CYC cycles before the next pattern
//   DWELL  | pattern[step_idx] driven for max(dwell[step_idx],1) cycles
//
// Ports:
//   clk_in, rst_n      : clock, async active-low reset
//   start, stop        : one-cycle control pulses (stop wins)
//   loop_en            : repeat table when set, checked on the last step's final cycle
//   seq_len            : active step count, captured at start
//   cfg                : table write bus (lattice_if.slave)
//   out                : registered relay drive, all ones = all off
//   step_idx           : current step
//   busy/step_stb/done : status; step_stb on first DWELL cycle, done at end of single pass
module lattice_seq
    import lattice_pkg::*;
#(
    parameter int N_RELAY   = 7,
    parameter int PINS      = 3,
    parameter int DEPTH     = 32,
    parameter int DWELL_W   = 24,
    parameter int GUARD_CYC = 1000
) (
    input  logic                     clk_in,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop_en,
    input  logic [$clog2(DEPTH):0]   seq_len,
    lattice_if.slave                 cfg,
    output logic [N_RELAY*PINS-1:0]  out,
    output logic [$clog2(DEPTH)-1:0] step_idx,
    output logic                     busy,
    output logic                     step_stb,
    output logic                     done
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int OW = N_RELAY * PINS;
    localparam int GW = $clog2(GUARD_CYC + 1);

    localparam logic [OW-1:0] ALL_OFF    = OW'(all_off(OW));
    localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYC - 1);
    localparam logic [LW-1:0] DEPTH_L    = LW'(DEPTH);

    state_t             state;
    logic [LW-1:0]      len;
    logic [GW-1:0]      guard_cnt;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [OW-1:0]      rd_pattern;
    logic [DWELL_W-1:0] rd_dwell;
    logic               tbl_we;
    logic               last_step;
    logic               start_ok;

    assign tbl_we    = cfg.cfg_we & ~busy;
    assign last_step = ({1'b0, step_idx} == (len - LW'(1)));
    assign start_ok  = start && (seq_len != '0) && (seq_len <= DEPTH_L);

    lattice_tbl #(
        .DEPTH   (DEPTH),
        .PAT_W   (OW),
        .DWELL_W (DWELL_W)
    ) u_tbl (
        .clk_in   (clk_in),
        .we       (tbl_we),
        .waddr    (cfg.cfg_addr),
        .wpattern (cfg.cfg_pattern),
        .wdwell   (cfg.cfg_dwell),
        .raddr    (step_idx),
        .rpattern (rd_pattern),
        .rdwell   (rd_dwell)
    );

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            out         <= ALL_OFF;
            step_idx    <= '0;
            busy        <= 1'b0;
            step_stb    <= 1'b0;
            done        <= 1'b0;
            cfg.cfg_err <= 1'b0;
            len         <= '0;
            guard_cnt   <= '0;
            dwell_cnt   <= '0;
        end else begin
            step_stb    <= 1'b0;
            done        <= 1'b0;
            cfg.cfg_err <= cfg.cfg_we & busy;

            if (stop) begin
                state    <= ST_IDLE;
                out      <= ALL_OFF;
                step_idx <= '0;
                busy     <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_ok) begin
                            len       <= seq_len;
                            step_idx  <= '0;
                            busy      <= 1'b1;
                            guard_cnt <= GUARD_LOAD;
                            state     <= ST_GUARD;
                        end
                    end

                    ST_GUARD: begin
                        if (guard_cnt == '0) begin
                            // step_idx already points at the new step, so the
                            // async table read is valid for loading here.
                            state     <= ST_DWELL;
                            out       <= rd_pattern;
                            step_stb  <= 1'b1;
                            dwell_cnt <= (rd_dwell == '0) ? '0 : rd_dwell - DWELL_W'(1);
                        end else begin
                            guard_cnt <= guard_cnt - GW'(1);
                        end
                    end

                    ST_DWELL: begin
                        if (dwell_cnt == '0) begin
                            out <= ALL_OFF;
                            if (!last_step) begin
                                step_idx  <= step_idx + AW'(1);
                                guard_cnt <= GUARD_LOAD;
                                state     <= ST_GUARD;
                            end else if (loop_en) begin
                                step_idx  <= '0;
                                guard_cnt <= GUARD_LOAD;
                                state     <= ST_GUARD;
                            end else begin
                                step_idx <= '0;
                                busy     <= 1'b0;
                                done     <= 1'b1;
                                state    <= ST_IDLE;
                            end
                        end else begin
                            dwell_cnt <= dwell_cnt - DWELL_W'(1);
                        end
                    end

                    default: begin
                        state <= ST_IDLE;
                        out   <= ALL_OFF;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
